// File: rtl/nrx_rom_pkg.sv
// Shared constants for the New Rally-X ROM download sequencer.
// Holds the FSM state encoding, the region count and the default image layout.
package nrx_rom_pkg;

    localparam int NRX_REGIONS = 4;

    localparam logic [15:0] NRX_R0_END = 16'h4000;
    localparam logic [15:0] NRX_R1_END = 16'h5000;
    localparam logic [15:0] NRX_R2_END = 16'h5100;
    localparam logic [15:0] NRX_R3_END = 16'h5120;

    localparam int NRX_HOLD_CYCLES = 1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2,
        ST_RUN  = 2'd3
    } nrx_state_e;

    // Plain constants so the FSM register stays a bare logic vector.
    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_LOAD = ST_LOAD;
    localparam logic [1:0] S_HOLD = ST_HOLD;
    localparam logic [1:0] S_RUN  = ST_RUN;

endpackage

// File: rtl/nrx_rom_loader_if.sv
// ioctl download stream in, rebased ROM write strobes and core control out.
// master = HPS/testbench side, slave = nrx_rom_loader.
interface nrx_rom_loader_if;
    import nrx_rom_pkg::*;

    logic                   dl_active;
    logic                   dl_wr;
    logic [24:0]            dl_addr;
    logic [7:0]             dl_data;
    logic [15:0]            rom_addr;
    logic [7:0]             rom_data;
    logic [NRX_REGIONS-1:0] rom_we;
    logic                   core_reset;
    logic                   dl_done;
    logic                   dl_err;
    logic [16:0]            byte_cnt;
    logic [7:0]             dl_sum;

    modport master (
        output dl_active, dl_wr, dl_addr, dl_data,
        input  rom_addr, rom_data, rom_we, core_reset, dl_done, dl_err, byte_cnt, dl_sum
    );

    modport slave (
        input  dl_active, dl_wr, dl_addr, dl_data,
        output rom_addr, rom_data, rom_we, core_reset, dl_done, dl_err, byte_cnt, dl_sum
    );

endinterface

// File: rtl/nrx_region_dec.sv
// Combinational ioctl address decoder: picks one of the four ROM regions and
// rebases the address to an offset inside it; anything past the last region is invalid.
module nrx_region_dec
    import nrx_rom_pkg::*;
#(
    parameter logic [15:0] R0_END = NRX_R0_END,
    parameter logic [15:0] R1_END = NRX_R1_END,
    parameter logic [15:0] R2_END = NRX_R2_END,
    parameter logic [15:0] R3_END = NRX_R3_END
) (
    input  logic [24:0]            addr_i,
    output logic                   valid_o,
    output logic [NRX_REGIONS-1:0] sel_o,
    output logic [15:0]            offset_o
);

    // Full 25-bit compares so any set bit in [24:16] falls out as invalid.
    always_comb begin
        valid_o  = 1'b0;
        sel_o    = '0;
        offset_o = '0;
        if (addr_i < {9'd0, R0_END}) begin
            valid_o  = 1'b1;
            sel_o    = 4'b0001;
            offset_o = addr_i[15:0];
        end else if (addr_i < {9'd0, R1_END}) begin
            valid_o  = 1'b1;
            sel_o    = 4'b0010;
            offset_o = addr_i[15:0] - R0_END;
        end else if (addr_i < {9'd0, R2_END}) begin
            valid_o  = 1'b1;
            sel_o    = 4'b0100;
            offset_o = addr_i[15:0] - R1_END;
        end else if (addr_i < {9'd0, R3_END}) begin
            valid_o  = 1'b1;
            sel_o    = 4'b1000;
            offset_o = addr_i[15:0] - R2_END;
        end
    end

endmodule

// File: rtl/nrx_rom_loader.sv
// New Rally-X ROM download sequencer: splits the ioctl stream into four regions and
// holds the core in reset until a download completes. Optional macro: NRX_ROM_CHECKSUM_EN.
module nrx_rom_loader
    import nrx_rom_pkg::*;
#(
    parameter logic [15:0] R0_END      = NRX_R0_END,
    parameter logic [15:0] R1_END      = NRX_R1_END,
    parameter logic [15:0] R2_END      = NRX_R2_END,
    parameter logic [15:0] R3_END      = NRX_R3_END,
    parameter int          HOLD_CYCLES = NRX_HOLD_CYCLES,
    parameter logic [7:0]  EXP_SUM     = 8'h00
) (
    input  logic             clk_sys,
    input  logic             RESET_N,
    nrx_rom_loader_if.slave  bus
);

    localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYCLES - 1);
    localparam logic [16:0] IMAGE_SIZE = {1'b0, R3_END};
    localparam logic [16:0] CNT_MAX    = 17'h1FFFF;

    logic [1:0]             state_q,      state_d;
    logic [15:0]            holdCnt_q,    holdCnt_d;
    logic [16:0]            byteCnt_q,    byteCnt_d;
    logic                   err_q,        err_d;
    logic [15:0]            romAddr_q,    romAddr_d;
    logic [7:0]             romData_q,    romData_d;
    logic [NRX_REGIONS-1:0] romWe_q,      romWe_d;
    logic                   coreReset_q,  coreReset_d;
    logic                   done_q,       done_d;

    logic                   decValid;
    logic [NRX_REGIONS-1:0] decSel;
    logic [15:0]            decOffset;
    logic                   accept;
    logic                   enterLoad;
    logic                   sumBad;

    nrx_region_dec #(
        .R0_END (R0_END),
        .R1_END (R1_END),
        .R2_END (R2_END),
        .R3_END (R3_END)
    ) u_dec (
        .addr_i   (bus.dl_addr),
        .valid_o  (decValid),
        .sel_o    (decSel),
        .offset_o (decOffset)
    );

    assign accept    = bus.dl_active & bus.dl_wr;
    assign enterLoad = bus.dl_active & (state_q != S_LOAD);

    // A write arriving on the very cycle LOAD is entered counts against the cleared statistics.
    always_comb begin
        state_d     = state_q;
        holdCnt_d   = holdCnt_q;
        byteCnt_d   = enterLoad ? 17'd0 : byteCnt_q;
        err_d       = enterLoad ? 1'b0 : err_q;
        romAddr_d   = romAddr_q;
        romData_d   = romData_q;
        romWe_d     = '0;
        coreReset_d = 1'b1;
        done_d      = 1'b0;

        if (bus.dl_active) begin
            state_d = S_LOAD;
            if (enterLoad) begin
                holdCnt_d = '0;
            end
        end else begin
            case (state_q)
                S_LOAD: begin
                    state_d   = S_HOLD;
                    holdCnt_d = '0;
                    if ((byteCnt_q != IMAGE_SIZE) || sumBad) begin
                        err_d = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (holdCnt_q == HOLD_LAST) begin
                        state_d     = S_RUN;
                        coreReset_d = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        holdCnt_d = holdCnt_q + 16'd1;
                    end
                end
                S_RUN: begin
                    coreReset_d = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        if (accept) begin
            if (byteCnt_d != CNT_MAX) begin
                byteCnt_d = byteCnt_d + 17'd1;
            end
            if (decValid) begin
                romWe_d   = decSel;
                romAddr_d = decOffset;
                romData_d = bus.dl_data;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            holdCnt_q   <= '0;
            byteCnt_q   <= '0;
            err_q       <= 1'b0;
            romAddr_q   <= '0;
            romData_q   <= '0;
            romWe_q     <= '0;
            coreReset_q <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            holdCnt_q   <= holdCnt_d;
            byteCnt_q   <= byteCnt_d;
            err_q       <= err_d;
            romAddr_q   <= romAddr_d;
            romData_q   <= romData_d;
            romWe_q     <= romWe_d;
            coreReset_q <= coreReset_d;
            done_q      <= done_d;
        end
    end

`ifdef NRX_ROM_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;

    // Only bytes that actually land in a region contribute to the checksum.
    always_comb begin
        sum_d = enterLoad ? 8'h00 : sum_q;
        if (accept && decValid) begin
            sum_d = sum_d + bus.dl_data;
        end
    end

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sumBad     = (sum_q != EXP_SUM);
    assign bus.dl_sum = sum_q;
`else
    assign sumBad     = 1'b0;
    assign bus.dl_sum = 8'h00;
`endif

    assign bus.rom_addr   = romAddr_q;
    assign bus.rom_data   = romData_q;
    assign bus.rom_we     = romWe_q;
    assign bus.core_reset = coreReset_q;
    assign bus.dl_done    = done_q;
    assign bus.dl_err     = err_q;
    assign bus.byte_cnt   = byteCnt_q;

endmodule

// File: tb/tb_nrx_rom_loader.sv
// Self-checking bench for nrx_rom_loader against a region-table model of the download rules.
// Honours NRX_ROM_CHECKSUM_EN when deciding expected dl_sum / dl_err.
module tb_nrx_rom_loader;
    import nrx_rom_pkg::*;

    localparam int HOLD  = 1024;
    localparam int IMAGE = 'h5120;
`ifdef NRX_ROM_CHECKSUM_EN
    localparam bit CKS = 1'b1;
`else
    localparam bit CKS = 1'b0;
`endif

    logic clk_sys = 1'b0;
    logic RESET_N;

    nrx_rom_loader_if bus();

    nrx_rom_loader #(
        .R0_END      (16'h4000),
        .R1_END      (16'h5000),
        .R2_END      (16'h5100),
        .R3_END      (16'h5120),
        .HOLD_CYCLES (HOLD),
        .EXP_SUM     (8'h00)
    ) dut (
        .clk_sys (clk_sys),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int         checks = 0;
    int         errors = 0;
    int         mCnt;
    bit         mErr;
    logic [7:0] mSum;
    int         hits [4];
    int         bounds [5] = '{0, 'h4000, 'h5000, 'h5100, 'h5120};

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode straight from the region table.
    task automatic modelDecode(input logic [24:0] a, output logic v, output logic [3:0] we,
                               output logic [15:0] off);
        v   = 1'b0;
        we  = 4'b0000;
        off = 16'h0000;
        for (int r = 0; r < 4; r++) begin
            if (int'(a) >= bounds[r] && int'(a) < bounds[r+1]) begin
                v   = 1'b1;
                we  = 4'(1 << r);
                off = 16'(int'(a) - bounds[r]);
            end
        end
    endtask

    task automatic modelClear();
        mCnt = 0;
        mErr = 1'b0;
        mSum = 8'h00;
        for (int r = 0; r < 4; r++) hits[r] = 0;
    endtask

    task automatic idleCycle();
        @(posedge clk_sys);
        #1;
    endtask

    // One dl_wr cycle; outputs are checked one clock later.
    task automatic applyStimulus(input logic [24:0] a, input logic [7:0] d);
        logic v;
        logic [3:0] we;
        logic [15:0] off;
        logic [3:0] expWe;
        modelDecode(a, v, we, off);
        bus.dl_wr   = 1'b1;
        bus.dl_addr = a;
        bus.dl_data = d;
        @(posedge clk_sys);
        #1;
        bus.dl_wr = 1'b0;
        expWe = 4'b0000;
        if (bus.dl_active) begin
            if (mCnt < 'h1FFFF) mCnt++;
            if (v) begin
                expWe = we;
                mSum  = mSum + d;
            end else begin
                mErr = 1'b1;
            end
        end
        checkOutput("rom_we", bus.rom_we, expWe);
        if (expWe != 4'b0000) begin
            checkOutput("rom_addr", bus.rom_addr, off);
            checkOutput("rom_data", bus.rom_data, d);
        end
        if (a == 25'h5005 && bus.dl_active) begin
            checkOutput("addr5005_off", bus.rom_addr, 16'h0005);
            checkOutput("addr5005_we", bus.rom_we, 4'b0100);
        end
        checkOutput("byte_cnt", bus.byte_cnt, mCnt);
        checkOutput("dl_err_load", bus.dl_err, mErr);
        for (int r = 0; r < 4; r++) if (bus.rom_we[r]) hits[r]++;
    endtask

    task automatic startDl();
        bus.dl_active = 1'b1;
        modelClear();
    endtask

    // Drop dl_active and verify the hold length, the done pulse and the final status.
    task automatic endDl();
        int relEdge;
        bit earlyDone;
        logic doneAtRel;
        relEdge   = 0;
        earlyDone = 1'b0;
        doneAtRel = 1'b0;
        bus.dl_active = 1'b0;
        if (mCnt != IMAGE) mErr = 1'b1;
        if (CKS && mSum != 8'h00) mErr = 1'b1;
        for (int i = 1; i <= HOLD + 60 && relEdge == 0; i++) begin
            @(posedge clk_sys);
            #1;
            if (i == 1) begin
                checkOutput("dl_err_final", bus.dl_err, mErr);
                checkOutput("byte_cnt_final", bus.byte_cnt, mCnt);
                checkOutput("dl_sum_final", bus.dl_sum, CKS ? mSum : 8'h00);
                checkOutput("rom_we_hold", bus.rom_we, 4'b0000);
            end
            if (bus.core_reset === 1'b0) begin
                relEdge   = i;
                doneAtRel = bus.dl_done;
            end else if (bus.dl_done !== 1'b0) begin
                earlyDone = 1'b1;
            end
        end
        checkOutput("release_latency", relEdge, HOLD + 1);
        checkOutput("done_at_release", doneAtRel, 1'b1);
        checkOutput("no_early_done", earlyDone, 1'b0);
        idleCycle();
        checkOutput("done_one_cycle", bus.dl_done, 1'b0);
        checkOutput("core_run", bus.core_reset, 1'b0);
        checkOutput("dl_err_run", bus.dl_err, mErr);
    endtask

    task automatic fullImage(input logic [7:0] target);
        logic [7:0] s;
        logic [7:0] d;
        s = 8'h00;
        startDl();
        for (int a = 0; a < IMAGE; a++) begin
            d = 8'($urandom);
            if (a == IMAGE - 1) d = target - s;
            s = s + d;
            applyStimulus(25'(a), d);
            if (a == 0) checkOutput("core_reset_rise", bus.core_reset, 1'b1);
        end
        checkOutput("hits_r0", hits[0], 'h4000);
        checkOutput("hits_r1", hits[1], 'h1000);
        checkOutput("hits_r2", hits[2], 'h100);
        checkOutput("hits_r3", hits[3], 'h20);
        endDl();
    endtask

    initial begin
        logic [24:0] a;
        bit seenBad;

        RESET_N       = 1'b0;
        bus.dl_active = 1'b0;
        bus.dl_wr     = 1'b0;
        bus.dl_addr   = '0;
        bus.dl_data   = '0;
        modelClear();
        repeat (3) idleCycle();

        checkOutput("rst_core_reset", bus.core_reset, 1'b1);
        checkOutput("rst_rom_we", bus.rom_we, 4'b0000);
        checkOutput("rst_rom_addr", bus.rom_addr, 16'h0000);
        checkOutput("rst_rom_data", bus.rom_data, 8'h00);
        checkOutput("rst_dl_done", bus.dl_done, 1'b0);
        checkOutput("rst_dl_err", bus.dl_err, 1'b0);
        checkOutput("rst_byte_cnt", bus.byte_cnt, 17'h0);
        checkOutput("rst_dl_sum", bus.dl_sum, 8'h00);

        // Idle after reset: core stays held, nothing written.
        RESET_N = 1'b1;
        seenBad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            idleCycle();
            if (bus.core_reset !== 1'b1 || bus.rom_we !== 4'b0000 || bus.dl_done !== 1'b0) seenBad = 1'b1;
        end
        checkOutput("idle_hold", seenBad, 1'b0);
        applyStimulus(25'h0010, 8'h5A);
        checkOutput("idle_wr_ignored_core", bus.core_reset, 1'b1);

        // Complete image whose checksum matches.
        fullImage(8'h00);

        // Write strobe with dl_active low while running.
        applyStimulus(25'h0100, 8'hAA);
        checkOutput("run_wr_ignored_core", bus.core_reset, 1'b0);

        // Short random download with out-of-range addresses and gaps.
        startDl();
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 3))
                0, 1:    a = 25'($urandom_range(0, 'h511F));
                2:       a = 25'($urandom_range('h5120, 'hFFFF));
                default: a = {9'($urandom_range(1, 511)), 16'($urandom_range(0, 'h5000))};
            endcase
            if (n == 3) a = 25'h5120;
            if (n == 5) a = 25'h511F;
            applyStimulus(a, 8'($urandom));
            if (n == 0) checkOutput("core_reset_rise_run", bus.core_reset, 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                idleCycle();
                checkOutput("gap_rom_we", bus.rom_we, 4'b0000);
            end
        end
        endDl();

        // Complete image whose checksum is 0x01.
        fullImage(8'h01);

        // Abort the hold after 500 clocks.
        startDl();
        for (int n = 0; n < 5; n++) applyStimulus(25'(n), 8'(n + 1));
        bus.dl_active = 1'b0;
        seenBad = 1'b0;
        for (int i = 0; i < 500; i++) begin
            idleCycle();
            if (bus.core_reset !== 1'b1 || bus.dl_done !== 1'b0) seenBad = 1'b1;
        end
        checkOutput("hold_before_abort", seenBad, 1'b0);
        startDl();
        idleCycle();
        checkOutput("abort_byte_cnt", bus.byte_cnt, 17'h0);
        checkOutput("abort_dl_err", bus.dl_err, 1'b0);
        checkOutput("abort_core_reset", bus.core_reset, 1'b1);
        checkOutput("abort_no_done", bus.dl_done, 1'b0);
        endDl();

        // Asynchronous reset in the middle of a download.
        startDl();
        for (int n = 0; n < 4; n++) applyStimulus(25'h4000 + 25'(n), 8'($urandom));
        RESET_N = 1'b0;
        #1;
        checkOutput("async_core_reset", bus.core_reset, 1'b1);
        checkOutput("async_byte_cnt", bus.byte_cnt, 17'h0);
        checkOutput("async_rom_we", bus.rom_we, 4'b0000);
        checkOutput("async_rom_addr", bus.rom_addr, 16'h0000);
        bus.dl_active = 1'b0;
        idleCycle();
        RESET_N = 1'b1;
        seenBad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            idleCycle();
            if (bus.core_reset !== 1'b1 || bus.dl_done !== 1'b0) seenBad = 1'b1;
        end
        checkOutput("post_reset_hold", seenBad, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nrx_rom_loader.md
# nrx_rom_loader

Download sequencer for the New Rally-X core: it takes the HPS ioctl byte stream, splits it into four ROM/PROM regions, and generates rebased write strobes into the core's block RAMs. It owns the core reset while ROMs are absent or loading, including a post-load settling hold, and flags size errors. It sits between hps_io and fpga_NRX, replacing the direct ROMCL/ROMAD/ROMDT/ROMEN hookup and the `ioctl_download` term of the core reset.

## Interface
Parameters:
- R0_END, 16'h4000, exclusive end of region 0 (CPU program ROM)
- R1_END, 16'h5000, exclusive end of region 1 (graphics ROM)
- R2_END, 16'h5100, exclusive end of region 2 (sound PROM)
- R3_END, 16'h5120, exclusive end of region 3 (colour PROMs); also the expected image size
- HOLD_CYCLES, 1024, core-reset hold after the download ends (1..65535)
- EXP_SUM, 8'h00, expected 8-bit additive checksum (used only with the checksum feature)

Ports:
- clk_sys in 1: system clock (24 MHz)
- RESET_N in 1: reset, asynchronous assert, active low
- dl_active in 1: ioctl_download
- dl_wr in 1: ioctl_wr, one-cycle byte strobe
- dl_addr in 25: ioctl_addr
- dl_data in 8: ioctl_dout
- rom_addr out 16: byte offset within the selected region
- rom_data out 8: write data
- rom_we out 4: one-hot region write enable
- core_reset out 1: active-high reset to the game core
- dl_done out 1: one-cycle pulse when the core is released
- dl_err out 1: sticky error from the last download
- byte_cnt out 17: bytes accepted in the current/last download, saturating
- dl_sum out 8: running checksum

## Operation
- States: IDLE, LOAD, HOLD, RUN. After reset the block is in IDLE. No ROM is valid in IDLE, so core_reset=1.
- From any state, dl_active=1 moves the block to LOAD. On entry to LOAD: byte_cnt=0, dl_sum=0, dl_err=0, and the hold counter is cleared.
- LOAD → HOLD when dl_active=0. At that transition dl_err is set if byte_cnt≠R3_END.
- HOLD counts HOLD_CYCLES clocks, then moves to RUN and pulses dl_done.
- RUN: core_reset=0. RUN has no exit except dl_active=1 or reset.
- core_reset is 1 in IDLE, LOAD and HOLD.
- Write acceptance: a write is accepted when dl_active=1 and dl_wr=1, in any state. The state change to LOAD happens in the same cycle.
- Region decode uses a=dl_addr:
  - a<R0_END → region 0, offset a
  - a<R1_END → region 1, offset a−R0_END
  - a<R2_END → region 2, offset a−R1_END
  - a<R3_END → region 3, offset a−R2_END
  - a≥R3_END, including any set bit in [24:16] → the write is dropped, dl_err=1, and byte_cnt still increments.
- byte_cnt increments per accepted write and saturates at 17'h1FFFF.
- Reset mid-operation: everything returns to IDLE and the core stays held until a full download completes.

## Timing
- Reset values:
  - state=IDLE, core_reset=1
  - rom_we=0, rom_addr=0, rom_data=0
  - dl_done=0, dl_err=0, byte_cnt=0, dl_sum=0
- All outputs are registered.
- Write latency is 1 clock. rom_addr, rom_data and rom_we are valid in the cycle after the accepted dl_wr, and rom_we is high for exactly one cycle.
- Back-to-back dl_wr on consecutive cycles is supported at full rate.
- core_reset rises 1 clock after dl_active rises.
- core_reset falls exactly HOLD_CYCLES+1 clocks after dl_active falls. dl_done is high in that same cycle.
- A final write coincident with dl_active falling is not accepted (dl_active=0 in that cycle).
- dl_active rising during HOLD aborts the hold. dl_done is not pulsed.

## Configuration
- NRX_ROM_CHECKSUM_EN defined:
  - dl_sum accumulates the 8-bit sum, mod 256, of every accepted in-range byte.
  - On LOAD→HOLD, dl_err is also set if dl_sum≠EXP_SUM.
- NRX_ROM_CHECKSUM_EN undefined:
  - dl_sum is tied to 0 and the checksum comparison is absent.
  - The port list is identical in both builds.

## Structure
- Package nrx_rom_pkg holds:
  - the state enum (IDLE/LOAD/HOLD/RUN)
  - the region count constant (4)
  - default region bounds and HOLD_CYCLES
- Sub-module nrx_region_dec: combinational dl_addr → {valid, 4-bit one-hot, 16-bit offset} against the four bounds. It is instantiated once.

## Test plan
- Reset release with dl_active low → core_reset stays 1 indefinitely, rom_we=0, dl_done never pulses.
- Full 0x5120-byte download with one write every 4 clocks → rom_we[0] on 0x4000 writes, rom_we[1] on 0x1000, rom_we[2] on 0x100, rom_we[3] on 0x20. Offset for addr 0x5005 is 0x0005 on rom_we=4'b0100. dl_err=0. dl_done pulses, and core_reset falls 1025 clocks after dl_active falls.
- Download of 0x5121 bytes → the write at 0x5120 is dropped, byte_cnt=0x5121, dl_err=1.
- Download of 0x5000 bytes → dl_err=1 after dl_active falls, and the core is still released after the hold.
- dl_active re-asserted 500 clocks into HOLD → no dl_done, byte_cnt=0 and dl_err=0 on the next cycle, core_reset stays 1.
- With NRX_ROM_CHECKSUM_EN and EXP_SUM=8'h00, image bytes summing to 8'h01 → dl_sum=8'h01 and dl_err=1. Without the macro, dl_sum=0 and dl_err=0.
